// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the requester-side and RAM-side signals of
//               mem_arbiter.
//               slave  - arbiter view (requests in, hits/RAM controls out)
//               master - environment view (pipeline requesters plus RAM)
//   Requester side : iREN, iaddr, dREN, dWEN, daddr, dstore,
//                    ihit, dhit, iload, dload
//   RAM side       : ramREN, ramWEN, ramaddr, ramstore, ramload, ramstate
//   Status         : arb_err
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        arb_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               arb_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               arb_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Single-port RAM arbiter between instruction fetch and data
//               memory. Data normally wins; after MAX_DSTREAK consecutive data
//               grants with a fetch pending, the fetch is forced through.
//               One RAM transaction in flight; FSM IDLE -> grant -> DONE.
// Ports       : CLK  - clock, rising edge
//               nRST - asynchronous active-low reset
//               bus  - mem_arbiter_if.slave (requests, hits, RAM controls)
// Options     : `define ARB_TIMEOUT_EN builds a per-grant wait counter; RAM
//               ERROR or TIMEOUT cycles without ACCESS abort the grant with
//               a hit plus arb_err and a zero load value. Without it arb_err
//               is tied low and ERROR is treated as BUSY.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic CLK,
    input  logic nRST,
    mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IGNT = 2'd1;
    localparam logic [1:0] DGNT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    logic [1:0]    state_q,    state_d;
    logic [SW-1:0] streak_q,   streak_d;
    logic [31:0]   addr_q,     addr_d;
    logic [31:0]   store_q,    store_d;
    logic          ren_q,      ren_d;
    logic          wen_q,      wen_d;
    logic          gnt_data_q, gnt_data_d;
    logic [31:0]   iload_q,    iload_d;
    logic [31:0]   dload_q,    dload_d;

    logic w_grant;
    logic w_forced;
    logic w_access;
    logic w_abort;

    assign w_grant  = (state_q == IGNT) || (state_q == DGNT);
    assign w_forced = bus.iREN && (streak_q == SW'(MAX_DSTREAK));
    assign w_access = w_grant && (bus.ramstate == RAM_ACCESS);

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] RAM_ERROR = 2'd3;

    logic [TW-1:0] wait_q, wait_d;
    logic          err_q,  err_d;

    // A real ACCESS takes priority over a simultaneous timeout.
    assign w_abort = w_grant && !w_access &&
                     ((bus.ramstate == RAM_ERROR) || (wait_q == TW'(TIMEOUT)));
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        store_d    = store_q;
        ren_d      = ren_q;
        wen_d      = wen_q;
        gnt_data_d = gnt_data_q;
        iload_d    = iload_q;
        dload_d    = dload_q;
`ifdef ARB_TIMEOUT_EN
        wait_d     = wait_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if ((bus.dREN || bus.dWEN) && !w_forced) begin
                    state_d    = DGNT;
                    gnt_data_d = 1'b1;
                    addr_d     = bus.daddr;
                    store_d    = bus.dstore;
                    wen_d      = bus.dWEN;
                    ren_d      = bus.dREN && !bus.dWEN;   // write wins
                    if (!bus.iREN)
                        streak_d = '0;
                    else if (streak_q != SW'(MAX_DSTREAK))
                        streak_d = streak_q + SW'(1);
`ifdef ARB_TIMEOUT_EN
                    wait_d = '0;
                    err_d  = 1'b0;
`endif
                end else if (bus.iREN) begin
                    state_d    = IGNT;
                    gnt_data_d = 1'b0;
                    addr_d     = bus.iaddr;
                    store_d    = '0;
                    wen_d      = 1'b0;
                    ren_d      = 1'b1;
                    streak_d   = '0;
`ifdef ARB_TIMEOUT_EN
                    wait_d = '0;
                    err_d  = 1'b0;
`endif
                end
            end
            IGNT, DGNT: begin
                if (w_access) begin
                    state_d = DONE;
                    if (gnt_data_q) dload_d = bus.ramload;
                    else            iload_d = bus.ramload;
                end else if (w_abort) begin
                    state_d = DONE;
                    if (gnt_data_q) dload_d = '0;
                    else            iload_d = '0;
`ifdef ARB_TIMEOUT_EN
                    err_d = 1'b1;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    wait_d = wait_q + TW'(1);
`endif
                end
            end
            default: state_d = IDLE;   // DONE: one cycle, requests ignored
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            addr_q     <= '0;
            store_q    <= '0;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            gnt_data_q <= 1'b0;
            iload_q    <= '0;
            dload_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            wait_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            store_q    <= store_d;
            ren_q      <= ren_d;
            wen_q      <= wen_d;
            gnt_data_q <= gnt_data_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
`ifdef ARB_TIMEOUT_EN
            wait_q     <= wait_d;
            err_q      <= err_d;
`endif
        end
    end

    // RAM controls come from the grant latch, gated by state so that an
    // asynchronous reset drops them immediately.
    assign bus.ramREN   = w_grant && ren_q;
    assign bus.ramWEN   = w_grant && wen_q;
    assign bus.ramaddr  = w_grant ? addr_q  : '0;
    assign bus.ramstore = w_grant ? store_q : '0;

    assign bus.ihit  = (state_q == DONE) && !gnt_data_q;
    assign bus.dhit  = (state_q == DONE) &&  gnt_data_q;
    assign bus.iload = iload_q;
    assign bus.dload = dload_q;

`ifdef ARB_TIMEOUT_EN
    assign bus.arb_err = (state_q == DONE) && err_q;
`else
    assign bus.arb_err = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A small RAM model
//               answers ACCESS after ram_lat grant cycles (or stays BUSY when
//               ram_stuck is set) and returns ramaddr ^ c_XK as read data.
//               Expected hits are queued when stimulus is applied and popped
//               when the arbiter completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam logic [31:0] c_XK = 32'h8C22_0044;

    typedef struct {
        bit          d;     // 1: data hit expected, 0: instruction hit
        logic [31:0] val;   // expected load value
    } exp_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    mem_arbiter_if bus();

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    int ram_cnt   = 0;
    int ram_lat   = 2;
    bit ram_stuck = 1'b0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(64)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // RAM model
    always @(posedge CLK)
        ram_cnt <= (bus.ramREN || bus.ramWEN) ? ram_cnt + 1 : 0;

    assign bus.ramstate = !(bus.ramREN || bus.ramWEN) ? 2'd0 :
                          ram_stuck                   ? 2'd1 :
                          (ram_cnt >= ram_lat)        ? 2'd2 : 2'd1;
    assign bus.ramload  = bus.ramaddr ^ c_XK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Advances until a hit/err strobe or the budget runs out; reports the
    // cycle of the strobe and the RAM controls seen in the first grant cycle.
    task automatic run_to_event(input int budget, output bit tmo,
                                output int hit_cyc, output int g_cyc,
                                output logic g_ren, output logic g_wen,
                                output logic [31:0] g_addr,
                                output logic [31:0] g_store);
        tmo = 1'b1; hit_cyc = 0; g_cyc = 0;
        g_ren = 1'b0; g_wen = 1'b0; g_addr = '0; g_store = '0;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (g_cyc == 0 && (bus.ramREN || bus.ramWEN)) begin
                g_cyc = c; g_ren = bus.ramREN; g_wen = bus.ramWEN;
                g_addr = bus.ramaddr; g_store = bus.ramstore;
            end
            if (bus.ihit || bus.dhit || bus.arb_err) begin
                hit_cyc = c; tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic clear_reqs();
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    endtask

    task automatic test_reset();
        clear_reqs();
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        nRST = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({bus.ihit, bus.dhit, bus.arb_err, bus.ramREN, bus.ramWEN} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {bus.ihit, bus.dhit, bus.arb_err, bus.ramREN, bus.ramWEN});
        end
        n_checks++;
        if ({bus.iload, bus.dload, bus.ramaddr, bus.ramstore} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_buses: got %h %h %h %h expected all zero",
                     bus.iload, bus.dload, bus.ramaddr, bus.ramstore);
        end
        @(negedge CLK) nRST = 1'b1;
        tick();
    endtask

    task automatic test_solo_fetch();
        bit tmo; int hc, gc; logic gr, gw; logic [31:0] ga, gs; exp_t e;
        ram_lat = 2;
        bus.iaddr = 32'h40; bus.iREN = 1'b1;
        exp_q.push_back('{1'b0, 32'h8C22_0004});
        run_to_event(50, tmo, hc, gc, gr, gw, ga, gs);
        bus.iREN = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (tmo || bus.ihit !== 1'b1 || bus.dhit !== 1'b0) begin
            n_fail++;
            $display("FAIL solo_hit: got ihit=%b dhit=%b tmo=%0d expected ihit=1 dhit=0",
                     bus.ihit, bus.dhit, tmo);
        end
        n_checks++;
        if (bus.iload !== e.val) begin
            n_fail++; $display("FAIL solo_iload: got %h expected %h", bus.iload, e.val);
        end
        n_checks++;
        if (gc != 1 || gr !== 1'b1 || gw !== 1'b0 || ga !== 32'h40 || gs !== 32'h0) begin
            n_fail++;
            $display("FAIL solo_grant: got cyc=%0d ren=%b wen=%b addr=%h store=%h expected 1 1 0 00000040 00000000",
                     gc, gr, gw, ga, gs);
        end
        n_checks++;
        if (hc != 4) begin
            n_fail++; $display("FAIL solo_latency: got cycle %0d expected 4", hc);
        end
        tick();
        n_checks++;
        if (bus.ihit !== 1'b0 || bus.ramREN !== 1'b0) begin
            n_fail++;
            $display("FAIL solo_pulse: got ihit=%b ramREN=%b expected 0 0", bus.ihit, bus.ramREN);
        end
    endtask

    task automatic test_simultaneous();
        bit tmo; int hc, gc; logic gr, gw; logic [31:0] ga, gs; exp_t e;
        ram_lat = 1;
        bus.iaddr = 32'h80; bus.iREN = 1'b1;
        bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF; bus.dWEN = 1'b1;
        exp_q.push_back('{1'b1, 32'h100 ^ c_XK});
        exp_q.push_back('{1'b0, 32'h80 ^ c_XK});
        run_to_event(50, tmo, hc, gc, gr, gw, ga, gs);
        bus.dWEN = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (tmo || bus.dhit !== 1'b1 || bus.ihit !== 1'b0 || bus.dload !== e.val) begin
            n_fail++;
            $display("FAIL simul_first: got dhit=%b ihit=%b dload=%h expected 1 0 %h",
                     bus.dhit, bus.ihit, bus.dload, e.val);
        end
        n_checks++;
        if (gw !== 1'b1 || gr !== 1'b0 || ga !== 32'h100 || gs !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL simul_write: got wen=%b ren=%b addr=%h store=%h expected 1 0 00000100 deadbeef",
                     gw, gr, ga, gs);
        end
        run_to_event(50, tmo, hc, gc, gr, gw, ga, gs);
        bus.iREN = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (tmo || bus.ihit !== 1'b1 || bus.dhit !== 1'b0 || bus.iload !== e.val) begin
            n_fail++;
            $display("FAIL simul_fetch: got ihit=%b dhit=%b iload=%h expected 1 0 %h",
                     bus.ihit, bus.dhit, bus.iload, e.val);
        end
        n_checks++;
        if (gr !== 1'b1 || gw !== 1'b0 || ga !== 32'h80 || gs !== 32'h0) begin
            n_fail++;
            $display("FAIL simul_fetch_grant: got ren=%b wen=%b addr=%h store=%h expected 1 0 00000080 00000000",
                     gr, gw, ga, gs);
        end
        tick();
    endtask

    task automatic test_both_rw();
        bit tmo; int hc, gc; logic gr, gw; logic [31:0] ga, gs; int extra;
        ram_lat = 0;
        bus.daddr = 32'h180; bus.dstore = 32'hA5A5_0F0F;
        bus.dREN = 1'b1; bus.dWEN = 1'b1;
        run_to_event(50, tmo, hc, gc, gr, gw, ga, gs);
        clear_reqs();
        n_checks++;
        if (tmo || bus.dhit !== 1'b1 || gw !== 1'b1 || gr !== 1'b0 || gs !== 32'hA5A5_0F0F) begin
            n_fail++;
            $display("FAIL both_rw: got dhit=%b wen=%b ren=%b store=%h expected 1 1 0 a5a50f0f",
                     bus.dhit, gw, gr, gs);
        end
        extra = 0;
        repeat (8) begin
            tick();
            if (bus.dhit || bus.ihit || bus.ramREN || bus.ramWEN) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++; $display("FAIL both_rw_once: got %0d extra active cycles expected 0", extra);
        end
    endtask

    task automatic test_starvation();
        bit tmo; int hc, gc; logic gr, gw; logic [31:0] ga, gs; exp_t e;
        ram_lat = 1;
        bus.iaddr = 32'h300; bus.daddr = 32'h200;
        bus.iREN = 1'b1; bus.dREN = 1'b1;
        for (int k = 0; k < 6; k++)
            exp_q.push_back(k == 4 ? '{1'b0, 32'h300 ^ c_XK} : '{1'b1, 32'h200 ^ c_XK});
        for (int k = 0; k < 6; k++) begin
            run_to_event(50, tmo, hc, gc, gr, gw, ga, gs);
            e = exp_q.pop_front();
            n_checks++;
            if (tmo || bus.dhit !== e.d || bus.ihit !== !e.d ||
                (e.d ? bus.dload : bus.iload) !== e.val) begin
                n_fail++;
                $display("FAIL starve_%0d: got ihit=%b dhit=%b tmo=%0d load=%h expected dhit=%b load=%h",
                         k, bus.ihit, bus.dhit, tmo, e.d ? bus.dload : bus.iload, e.d, e.val);
            end
        end
        clear_reqs();
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_write();
        bit tmo; int hc, gc; logic gr, gw; logic [31:0] ga, gs; int hits;
        ram_stuck = 1'b1;
        bus.daddr = 32'h600; bus.dstore = 32'h1234_5678; bus.dWEN = 1'b1;
        run_to_event(5, tmo, hc, gc, gr, gw, ga, gs);
        n_checks++;
        if (!tmo || gw !== 1'b1 || bus.ramWEN !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_setup: got tmo=%0d wen=%b ramWEN=%b expected 1 1 1",
                     tmo, gw, bus.ramWEN);
        end
        #2 nRST = 1'b0;
        #1;
        n_checks++;
        if (bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got ramWEN=%b ramREN=%b expected 0 0", bus.ramWEN, bus.ramREN);
        end
        bus.dWEN = 1'b0;
        ram_stuck = 1'b0;
        hits = 0;
        repeat (2) begin tick(); if (bus.dhit || bus.ihit) hits++; end
        @(negedge CLK) nRST = 1'b1;
        repeat (3) begin
            tick();
            if (bus.dhit || bus.ihit || bus.ramREN || bus.ramWEN) hits++;
        end
        n_checks++;
        if (hits != 0) begin
            n_fail++; $display("FAIL rst_mid_idle: got %0d active cycles expected 0", hits);
        end
    endtask

    task automatic test_timeout();
        bit tmo; int hc, gc; logic gr, gw; logic [31:0] ga, gs;
        ram_stuck = 1'b1;
        bus.daddr = 32'h500; bus.dREN = 1'b1;
`ifdef ARB_TIMEOUT_EN
        run_to_event(100, tmo, hc, gc, gr, gw, ga, gs);
        bus.dREN = 1'b0;
        n_checks++;
        if (tmo || bus.dhit !== 1'b1 || bus.arb_err !== 1'b1 || bus.ihit !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: got dhit=%b arb_err=%b ihit=%b tmo=%0d expected 1 1 0",
                     bus.dhit, bus.arb_err, bus.ihit, tmo);
        end
        n_checks++;
        if (hc - gc != 65) begin
            n_fail++; $display("FAIL timeout_cycles: got %0d expected 65", hc - gc);
        end
        n_checks++;
        if (bus.dload !== 32'h0) begin
            n_fail++; $display("FAIL timeout_dload: got %h expected 00000000", bus.dload);
        end
        ram_stuck = 1'b0;
        tick();
`else
        run_to_event(200, tmo, hc, gc, gr, gw, ga, gs);
        n_checks++;
        if (!tmo || gc != 1 || bus.ramREN !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_hang: got tmo=%0d grant_cyc=%0d ramREN=%b expected 1 1 1",
                     tmo, gc, bus.ramREN);
        end
        n_checks++;
        if (bus.arb_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_err: got %b expected 0", bus.arb_err);
        end
        bus.dREN = 1'b0;
        ram_stuck = 1'b0;
        #2 nRST = 1'b0;
        @(negedge CLK) nRST = 1'b1;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_solo_fetch();
        test_simultaneous();
        test_both_rw();
        test_starvation();
        test_reset_mid_write();
        test_timeout();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
